cnf_loader: RTL

- Writer side of the clause database RAM. The solver core only reads that RAM (write enable tied low).
- Accepts a host literal stream over a valid/ready handshake and packs each clause into one clause-DB word.
- Writes the packed words to consecutive clause indices and reports the clause count.
- Signals load_done so control can be started. Sits between the host/config interface and clause_db_ram.

---
 rtl/cnf_loader_if.sv | 22 ++
 rtl/cnf_loader.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/cnf_loader_if.sv
// Host literal stream into the clause loader: one literal per beat,
// qualified by lit_valid/lit_ready.
interface cnf_loader_if #(
  parameter int MAX_VARS_BITS = 9
);
  logic                     lit_valid;
  logic                     lit_ready;
  logic [MAX_VARS_BITS-1:0] lit_var;
  logic                     lit_pol;
  logic                     lit_last;
  logic                     form_last;

  modport master (
    output lit_valid, lit_var, lit_pol, lit_last, form_last,
    input  lit_ready
  );

  modport slave (
    input  lit_valid, lit_var, lit_pol, lit_last, form_last,
    output lit_ready
  );
endinterface

// File: rtl/cnf_loader.sv
// Clause-DB writer: packs a host literal stream into one word per clause.
// Optional CNF_LOADER_DEDUP_EN drops repeated literals and skips tautologies.
module cnf_loader #(
  parameter int VAR_PER_CLAUSE   = 5,
  parameter int MAX_VARS_BITS    = 9,
  parameter int MAX_CLAUSES_BITS = 10,
  parameter int CLAUSE_DATA_BITS = VAR_PER_CLAUSE * (MAX_VARS_BITS + 2)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        load_start,
  cnf_loader_if.slave                 lit,
  output logic                        cdb_wren,
  output logic [MAX_CLAUSES_BITS-1:0] cdb_address,
  output logic [CLAUSE_DATA_BITS-1:0] cdb_data,
  output logic [MAX_CLAUSES_BITS:0]   num_clauses,
  output logic                        load_busy,
  output logic                        load_done,
  output logic                        load_err,
  output logic [1:0]                  err_code
);

  localparam int W        = MAX_VARS_BITS + 2;
  localparam int CNT_BITS = $clog2(VAR_PER_CLAUSE + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_COLLECT, S_WRITE, S_DONE, S_ERROR
  } state_e;

  state_e                      state_q, state_d;
  logic [MAX_VARS_BITS-1:0]    slot_var_q [VAR_PER_CLAUSE];
  logic [MAX_VARS_BITS-1:0]    slot_var_d [VAR_PER_CLAUSE];
  logic [VAR_PER_CLAUSE-1:0]   slot_pol_q, slot_pol_d;
  logic [CNT_BITS-1:0]         count_q, count_d;
  logic [MAX_CLAUSES_BITS-1:0] clause_idx_q, clause_idx_d;
  logic [MAX_CLAUSES_BITS:0]   num_q, num_d;
  logic                        form_last_q, form_last_d;
  logic                        taut_q, taut_d;
  logic [1:0]                  err_q, err_d;

  logic                        match_any;
`ifdef CNF_LOADER_DEDUP_EN
  logic                        match_same;
`endif
  logic [CLAUSE_DATA_BITS-1:0] packed_word;

  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q      <= S_IDLE;
      // NOTE: the slot array is a handful of flops, not a RAM, so it is cleared on reset too.
      for (int i = 0; i < VAR_PER_CLAUSE; i++) slot_var_q[i] <= '0;
      slot_pol_q   <= '0;
      count_q      <= '0;
      clause_idx_q <= '0;
      num_q        <= '0;
      form_last_q  <= 1'b0;
      taut_q       <= 1'b0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      slot_var_q   <= slot_var_d;
      slot_pol_q   <= slot_pol_d;
      count_q      <= count_d;
      clause_idx_q <= clause_idx_d;
      num_q        <= num_d;
      form_last_q  <= form_last_d;
      taut_q       <= taut_d;
      err_q        <= err_d;
    end
  end

  // Duplicate detection only looks at slots already filled in this clause.
  always_comb begin
    match_any = 1'b0;
`ifdef CNF_LOADER_DEDUP_EN
    match_same = 1'b0;
`endif
    for (int i = 0; i < VAR_PER_CLAUSE; i++) begin
      if (i < int'(count_q) && slot_var_q[i] == lit.lit_var) begin
        match_any = 1'b1;
`ifdef CNF_LOADER_DEDUP_EN
        if (slot_pol_q[i] == lit.lit_pol) match_same = 1'b1;
`endif
      end
    end
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case can infer a latch.
    state_d      = state_q;
    slot_var_d   = slot_var_q;
    slot_pol_d   = slot_pol_q;
    count_d      = count_q;
    clause_idx_d = clause_idx_q;
    num_d        = num_q;
    form_last_d  = form_last_q;
    taut_d       = taut_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (load_start) begin
          state_d      = S_COLLECT;
          for (int i = 0; i < VAR_PER_CLAUSE; i++) slot_var_d[i] = '0;
          slot_pol_d   = '0;
          count_d      = '0;
          clause_idx_d = '0;
          num_d        = '0;
          form_last_d  = 1'b0;
          taut_d       = 1'b0;
          err_d        = '0;
        end
      end
      S_COLLECT: begin
        if (lit.lit_valid) begin
          if (int'(count_q) == VAR_PER_CLAUSE) begin
            state_d = S_ERROR;
            err_d   = 2'd1;
          end else if (match_any) begin
`ifdef CNF_LOADER_DEDUP_EN
            if (!match_same) taut_d = 1'b1;
`else
            state_d = S_ERROR;
            err_d   = 2'd2;
`endif
          end else begin
            slot_var_d[count_q] = lit.lit_var;
            slot_pol_d[count_q] = lit.lit_pol;
            count_d             = count_q + 1'b1;
          end
          // An error on this beat wins over closing the clause.
          if (state_d == S_COLLECT && lit.lit_last) begin
            form_last_d = lit.form_last;
            state_d     = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        for (int i = 0; i < VAR_PER_CLAUSE; i++) slot_var_d[i] = '0;
        slot_pol_d = '0;
        count_d    = '0;
        taut_d     = 1'b0;
        if (!taut_q) begin
          clause_idx_d = clause_idx_q + 1'b1;
          num_d        = num_q + 1'b1;
        end
        if (form_last_q) begin
          state_d = S_DONE;
        end else if (!taut_q && clause_idx_d == '0) begin
          state_d = S_ERROR;
          err_d   = 2'd3;
        end else begin
          state_d = S_COLLECT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Unused slots have mask=0 and read as all-zero.
  always_comb begin
    packed_word = '0;
    for (int i = 0; i < VAR_PER_CLAUSE; i++) begin
      if (i < int'(count_q)) packed_word[i*W +: W] = {1'b1, slot_pol_q[i], slot_var_q[i]};
    end
  end

  assign lit.lit_ready = (state_q == S_COLLECT);
  assign cdb_wren      = (state_q == S_WRITE) && !taut_q;
  assign cdb_address   = clause_idx_q;
  assign cdb_data      = cdb_wren ? packed_word : '0;
  assign num_clauses   = num_q;
  assign load_busy     = (state_q == S_COLLECT) || (state_q == S_WRITE);
  assign load_done     = (state_q == S_DONE);
  assign load_err      = (state_q == S_ERROR);
  assign err_code      = err_q;

endmodule
